// File: rtl/cluster_sequencer.sv
// Layer sequencer: fetches bias/input/weight beats from synchronous memories, streams them to a
// cluster and writes one activation per pass to a result buffer. Define CLUSTER_SEQ_WDOG_EN for the watchdog/timeout.
// Handshake: a beat transfers on any cycle with tvalid && tready; tdata/tvalid stay stable until then.

module cluster_seq_fetch #(
  parameter int W     = 4,
  parameter int LIMIT = 8,
  parameter int CW    = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] base,
  input  logic [W-1:0]  rdata,
  input  logic          tready,
  output logic          rd,
  output logic [AW-1:0] addr,
  output logic [W-1:0]  tdata,
  output logic          tvalid,
  output logic          complete
);
  logic [CW-1:0] cnt;
  logic          rd_q;
  logic          held_v;
  logic [W-1:0]  held_d;
  logic          hs;

  // Memory data is presented straight from rdata in the cycle after the read and is
  // captured into the holding register only if the consumer stalls.
  assign tvalid   = rd_q || held_v;
  assign tdata    = rd_q ? rdata : held_d;
  assign hs       = tvalid && tready;
  assign rd       = en && (cnt < CW'(LIMIT)) && (!tvalid || hs);
  assign addr     = base + AW'(cnt);
  assign complete = (cnt == CW'(LIMIT)) && (!tvalid || hs);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt    <= '0;
      rd_q   <= 1'b0;
      held_v <= 1'b0;
      held_d <= '0;
    end else begin
      rd_q <= rd;
      if (rd) cnt <= cnt + 1'b1;
      if (rd_q && !hs) begin
        held_d <= rdata;
        held_v <= 1'b1;
      end else if (hs) begin
        held_v <= 1'b0;
      end
    end
  end
endmodule

module cluster_sequencer #(
  parameter int BITWIDTH   = 4,
  parameter int X_LANES    = 3,
  parameter int W_LANES    = 16,
  parameter int B_LANES    = 16,
  parameter int NUM_BEATS  = 8,
  parameter int NUM_PASSES = 2,
  parameter int AW         = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [2:0]                  cfg_mode,
  output logic                        busy,
  output logic                        done,
  output logic [AW-1:0]               x_addr,
  output logic [AW-1:0]               w_addr,
  output logic [AW-1:0]               b_addr,
  output logic                        x_rd,
  output logic                        w_rd,
  output logic                        b_rd,
  input  logic [X_LANES*BITWIDTH-1:0] x_rdata,
  input  logic [W_LANES*BITWIDTH-1:0] w_rdata,
  input  logic [B_LANES*BITWIDTH-1:0] b_rdata,
  output logic [X_LANES*BITWIDTH-1:0] x_tdata,
  output logic                        x_tvalid,
  input  logic                        x_tready,
  output logic [W_LANES*BITWIDTH-1:0] w_tdata,
  output logic                        w_tvalid,
  input  logic                        w_tready,
  output logic [B_LANES*BITWIDTH-1:0] b_tdata,
  output logic                        b_tvalid,
  input  logic                        b_tready,
  input  logic [BITWIDTH-1:0]         a_tdata,
  input  logic                        a_tvalid,
  output logic                        a_tready,
  output logic [2:0]                  configure,
  input  logic [1:0]                  status,
  output logic                        res_we,
  output logic [AW-1:0]               res_addr,
  output logic [BITWIDTH-1:0]         res_wdata,
  output logic [1:0]                  last_status,
  output logic [1:0]                  dbg_state
`ifdef CLUSTER_SEQ_WDOG_EN
  ,
  output logic                        timeout
`endif
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PASS = 2'd1, S_WAIT_A = 2'd2, S_DONE = 2'd3} state_t;

  localparam int PW  = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int XCW = $clog2(NUM_BEATS + 1);

  state_t        state, state_next;
  logic [PW-1:0] pass;
  logic          fetch_en, a_hs, last_pass, wdog_hit;
  logic          x_cmp, w_cmp, b_cmp;
  logic [AW-1:0] pass_a, w_base;

  assign fetch_en  = (state == S_PASS);
  assign a_tready  = (state == S_WAIT_A);
  assign a_hs      = a_tvalid && a_tready;
  assign last_pass = (pass == PW'(NUM_PASSES - 1));
  assign busy      = (state == S_PASS) || (state == S_WAIT_A);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign res_we    = a_hs;
  assign res_addr  = pass_a;
  assign res_wdata = a_hs ? a_tdata : '0;
  assign pass_a    = AW'(pass);
  assign w_base    = pass_a * AW'(NUM_BEATS);

  cluster_seq_fetch #(.W(B_LANES*BITWIDTH), .LIMIT(1), .CW(1), .AW(AW)) u_b (
    .clk(CLK), .rst(RST), .en(fetch_en), .base(pass_a), .rdata(b_rdata), .tready(b_tready),
    .rd(b_rd), .addr(b_addr), .tdata(b_tdata), .tvalid(b_tvalid), .complete(b_cmp));

  // Inputs are reused every pass, so the x stream always starts at address 0.
  cluster_seq_fetch #(.W(X_LANES*BITWIDTH), .LIMIT(NUM_BEATS), .CW(XCW), .AW(AW)) u_x (
    .clk(CLK), .rst(RST), .en(fetch_en), .base('0), .rdata(x_rdata), .tready(x_tready),
    .rd(x_rd), .addr(x_addr), .tdata(x_tdata), .tvalid(x_tvalid), .complete(x_cmp));

  cluster_seq_fetch #(.W(W_LANES*BITWIDTH), .LIMIT(NUM_BEATS), .CW(XCW), .AW(AW)) u_w (
    .clk(CLK), .rst(RST), .en(fetch_en), .base(w_base), .rdata(w_rdata), .tready(w_tready),
    .rd(w_rd), .addr(w_addr), .tdata(w_tdata), .tvalid(w_tvalid), .complete(w_cmp));

`ifdef CLUSTER_SEQ_WDOG_EN
  logic [15:0] wdog;
  logic        any_hs;

  assign any_hs   = (x_tvalid && x_tready) || (w_tvalid && w_tready) ||
                    (b_tvalid && b_tready) || a_hs;
  assign wdog_hit = busy && (wdog == 16'hFFFF);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == S_IDLE && start) timeout <= 1'b0;
      else if (wdog_hit)            timeout <= 1'b1;
      if (any_hs || !busy) wdog <= '0;
      else                 wdog <= wdog + 16'd1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_PASS;
      S_PASS:   if (x_cmp && w_cmp && b_cmp) state_next = S_WAIT_A;
      S_WAIT_A: if (a_hs) state_next = last_pass ? S_DONE : S_PASS;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (wdog_hit) state_next = S_DONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      pass        <= '0;
      configure   <= '0;
      last_status <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        pass      <= '0;
        configure <= cfg_mode;
      end
      if (a_hs) begin
        last_status <= status;
        if (!last_pass) pass <= pass + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cluster_sequencer.sv
// Directed bench for cluster_sequencer: memory models, stream/activation stubs and a
// transaction-level model (expected beat queues per stream, expected result writes).

module tb_cluster_sequencer;
  localparam int BITWIDTH = 4, X_LANES = 3, W_LANES = 16, B_LANES = 16;
  localparam int NUM_BEATS = 8, NUM_PASSES = 2, AW = 8;
  localparam int XW = X_LANES * BITWIDTH, WW = W_LANES * BITWIDTH, BW = B_LANES * BITWIDTH;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic [2:0] cfg_mode = 3'd0;
  logic busy, done, x_rd, w_rd, b_rd, x_tvalid, w_tvalid, b_tvalid, a_tready, res_we;
  logic [AW-1:0] x_addr, w_addr, b_addr, res_addr;
  logic [XW-1:0] x_rdata = '0, x_tdata;
  logic [WW-1:0] w_rdata = '0, w_tdata;
  logic [BW-1:0] b_rdata = '0, b_tdata;
  logic x_tready = 1'b1, w_tready = 1'b1, b_tready = 1'b1, a_tvalid = 1'b0;
  logic [BITWIDTH-1:0] a_tdata, res_wdata;
  logic [2:0] configure;
  logic [1:0] status = 2'd0, last_status, dbg_state;
`ifdef CLUSTER_SEQ_WDOG_EN
  logic timeout;
`endif

  cluster_sequencer #(
    .BITWIDTH(BITWIDTH), .X_LANES(X_LANES), .W_LANES(W_LANES), .B_LANES(B_LANES),
    .NUM_BEATS(NUM_BEATS), .NUM_PASSES(NUM_PASSES), .AW(AW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .cfg_mode(cfg_mode), .busy(busy), .done(done),
    .x_addr(x_addr), .w_addr(w_addr), .b_addr(b_addr), .x_rd(x_rd), .w_rd(w_rd), .b_rd(b_rd),
    .x_rdata(x_rdata), .w_rdata(w_rdata), .b_rdata(b_rdata),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
    .configure(configure), .status(status), .res_we(res_we), .res_addr(res_addr),
    .res_wdata(res_wdata), .last_status(last_status), .dbg_state(dbg_state)
`ifdef CLUSTER_SEQ_WDOG_EN
    , .timeout(timeout)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  logic rst_s;
  always @(posedge CLK) rst_s <= RST;

  // ---------------- memory models (read data valid the cycle after rd) ----------------
  logic [XW-1:0] x_mem [256];
  logic [WW-1:0] w_mem [256];
  logic [BW-1:0] b_mem [256];
  always @(posedge CLK) begin
    if (x_rd) x_rdata <= x_mem[x_addr];
    if (w_rd) w_rdata <= w_mem[w_addr];
    if (b_rd) b_rdata <= b_mem[b_addr];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, errors = 0;
  logic [XW-1:0] exp_x_q[$];
  logic [WW-1:0] exp_w_q[$];
  logic [BW-1:0] exp_b_q[$];
  int x_seen = 0, w_seen = 0, b_seen = 0, wr_k = 0, done_cnt = 0, cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic [2:0] exp_cfg = 3'd0;
  logic [3:0] act_base = 4'd0;
  logic [BITWIDTH-1:0] res_buf [4];
  logic prev_final_wr = 1'b0, prev_done = 1'b0, stat_pending = 1'b0;
  logic [1:0] hs_status = 2'd0;
  logic x_hold = 1'b0, w_hold = 1'b0, b_hold = 1'b0;
  logic [XW-1:0] x_hold_d;
  logic [WW-1:0] w_hold_d;
  logic [BW-1:0] b_hold_d;
  bit wdog_mode = 1'b0;
  int x_mode = 0, w_mode = 0, b_mode = 0, a_mode = 0;

  assign a_tdata = act_base + 4'(wr_k);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_x_q.delete(); exp_w_q.delete(); exp_b_q.delete();
    x_seen = 0; w_seen = 0; b_seen = 0; wr_k = 0;
    prev_final_wr = 1'b0; stat_pending = 1'b0;
    x_hold = 1'b0; w_hold = 1'b0; b_hold = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    cyc++;
    if (rst_s) begin
      chk("rst_valids", 64'({x_tvalid, w_tvalid, b_tvalid}), 64'd0);
      chk("rst_busy_done_we_ardy", 64'({busy, done, res_we, a_tready}), 64'd0);
      chk("rst_last_status", 64'(last_status), 64'd0);
      clear_model();
      prev_done = 1'b0;
    end else begin
      if (x_hold) chk("x_hold", 64'({x_tvalid, x_tdata}), 64'({1'b1, x_hold_d}));
      if (w_hold) chk("w_hold", 64'({w_tvalid, w_tdata}), 64'({1'b1, w_hold_d}));
      if (b_hold) chk("b_hold", 64'({b_tvalid, b_tdata}), 64'({1'b1, b_hold_d}));
      x_hold = x_tvalid && !x_tready; x_hold_d = x_tdata;
      w_hold = w_tvalid && !w_tready; w_hold_d = w_tdata;
      b_hold = b_tvalid && !b_tready; b_hold_d = b_tdata;

      if (x_tvalid && x_tready) begin
        last_hs_cyc = cyc;
        if (exp_x_q.size() == 0) chk("x_extra_beat", 64'd1, 64'd0);
        else chk("x_beat", 64'(x_tdata), 64'(exp_x_q.pop_front()));
        x_seen++;
      end
      if (w_tvalid && w_tready) begin
        last_hs_cyc = cyc;
        if (exp_w_q.size() == 0) chk("w_extra_beat", 64'd1, 64'd0);
        else chk("w_beat", w_tdata, exp_w_q.pop_front());
        w_seen++;
      end
      if (b_tvalid && b_tready) begin
        last_hs_cyc = cyc;
        if (exp_b_q.size() == 0) chk("b_extra_beat", 64'd1, 64'd0);
        else chk("b_beat", b_tdata, exp_b_q.pop_front());
        b_seen++;
      end

      if (stat_pending) chk("last_status", 64'(last_status), 64'(hs_status));
      stat_pending = 1'b0;

      // The activation may only be taken once every beat of the current pass has gone out.
      if (a_tready)
        chk("a_tready_early", 64'(x_seen == (wr_k + 1) * NUM_BEATS && w_seen == (wr_k + 1) * NUM_BEATS &&
                                  b_seen == wr_k + 1), 64'd1);
      chk("res_we", 64'(res_we), 64'(a_tvalid && a_tready));

      if (!wdog_mode) chk("done", 64'(done), 64'(prev_final_wr));
      if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
      if (busy) chk("configure", 64'(configure), 64'(exp_cfg));

      prev_final_wr = 1'b0;
      if (a_tvalid && a_tready) begin
        last_hs_cyc = cyc;
        chk("res_addr", 64'(res_addr), 64'(wr_k));
        chk("res_wdata", 64'(res_wdata), 64'(4'(act_base + 4'(wr_k))));
        res_buf[wr_k[1:0]] = res_wdata;
        hs_status = status;
        stat_pending = 1'b1;
        prev_final_wr = (wr_k == NUM_PASSES - 1);
        wr_k++;
      end

      prev_done = done;
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        done_cnt++;
        done_cyc = cyc;
        if (!wdog_mode) begin
          chk("x_all_delivered", 64'(x_seen), 64'(NUM_PASSES * NUM_BEATS));
          chk("queues_drained", 64'(exp_x_q.size() + exp_w_q.size() + exp_b_q.size()), 64'd0);
        end
        x_seen = 0; w_seen = 0; b_seen = 0; wr_k = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy(input int mode, input logic cur);
    if (mode == 1) return ~cur;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge CLK); #1;
      x_tready = rdy(x_mode, x_tready);
      w_tready = rdy(w_mode, w_tready);
      b_tready = rdy(b_mode, b_tready);
      a_tvalid = (a_mode == 0) ? 1'b1 : (a_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      status   = 2'($urandom_range(0, 3));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic fill_mem(input int style);
    for (int i = 0; i < 256; i++) begin
      if (style == 0) begin
        x_mem[i] = 12'h111;
        w_mem[i] = {W_LANES{4'h4}};
        b_mem[i] = '0;
      end else begin
        x_mem[i] = XW'(i * 173 + 17);
        w_mem[i] = {4{16'(i * 2017 + 99)}};
        b_mem[i] = {4{16'(i * 4099 + 5)}};
      end
    end
  endtask

  // Expected beats: bias[pass]; inputs 0..NUM_BEATS-1 every pass; weights pass*NUM_BEATS+beat.
  task automatic start_layer(input logic [2:0] cfg, input logic [3:0] base);
    for (int p = 0; p < NUM_PASSES; p++) begin
      exp_b_q.push_back(b_mem[p]);
      for (int b = 0; b < NUM_BEATS; b++) begin
        exp_x_q.push_back(x_mem[b]);
        exp_w_q.push_back(w_mem[(p * NUM_BEATS + b) % 256]);
      end
    end
    exp_cfg = cfg;
    act_base = base;
    cfg_mode = cfg;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode = 3'd0;
    chk("lat_rd_T1", 64'({x_rd, w_rd, b_rd, busy}), 64'hF);
    chk("lat_addr_T1", 64'({x_addr, w_addr, b_addr}), 64'd0);
    tick();
    chk("lat_valid_T2", 64'({x_tvalid, w_tvalid, b_tvalid}), 64'h7);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk("done_within_budget", 64'(done_cnt > d0), 64'd1);
    tick(2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, n;
    fill_mem(0);
    tick(3);
    RST = 1'b0;
    tick();
    chk("idle_outputs", 64'({busy, done, res_we, configure, res_addr}), 64'd0);

    // Layer A: constant memories, everything ready, activation offered from the start.
    start_layer(3'd0, 4'h5);
    wait_done(500);
    chk("a_res0", 64'(res_buf[0]), 64'h5);
    chk("a_res1", 64'(res_buf[1]), 64'h6);
    chk("a_done_once", 64'(done_cnt), 64'd1);

    // Layer B: distinct memory words, x_tready toggling, random w/b readies and activation valid,
    // plus an ignored start mid-layer.
    fill_mem(1);
    x_mode = 1; w_mode = 2; b_mode = 2; a_mode = 1;
    start_layer(3'd0, 4'h9);
    tick(6);
    cfg_mode = 3'd7; start = 1'b1;
    tick();
    start = 1'b0; cfg_mode = 3'd0;
    chk("b_cfg_kept", 64'(configure), 64'd0);
    wait_done(1000);
    chk("b_res0", 64'(res_buf[0]), 64'h9);
    chk("b_res1", 64'(res_buf[1]), 64'hA);
    chk("b_done_count", 64'(done_cnt), 64'd2);

    // Layer C: reset during pass 1, then a clean layer.
    x_mode = 2; w_mode = 2; b_mode = 0; a_mode = 0;
    start_layer(3'd3, 4'h2);
    n = 0;
    while (wr_k == 0 && n < 500) begin tick(); n++; end
    chk("c_reached_pass1", 64'(wr_k), 64'd1);
    tick(3);
    d0 = done_cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick(20);
    chk("c_no_done_after_abort", 64'(done_cnt), 64'(d0));
    chk("c_idle_after_abort", 64'({busy, configure}), 64'd0);
    start_layer(3'd3, 4'hC);
    wait_done(1000);
    chk("c_res0", 64'(res_buf[0]), 64'hC);
    chk("c_res1", 64'(res_buf[1]), 64'hD);
    chk("c_done_count", 64'(done_cnt), 64'(d0 + 1));

`ifdef CLUSTER_SEQ_WDOG_EN
    // Watchdog: the cluster never answers, so the layer is closed by the timeout.
    x_mode = 0; w_mode = 0; b_mode = 0; a_mode = 2;
    wdog_mode = 1'b1;
    start_layer(3'd1, 4'h0);
    wait_done(70000);
    chk("wdog_timeout", 64'(timeout), 64'd1);
    chk("wdog_gap_ok", 64'((done_cyc - last_hs_cyc) >= 65533 && (done_cyc - last_hs_cyc) <= 65540), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
